// File: rtl/fetch_queue.sv
// Dual-issue fetch-to-decode instruction buffer.
// Takes up to two {PC, instr} slots per cycle and presents the two oldest entries to decode.
module fetch_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned XLEN      = 32,
    parameter bit          DROP_ZERO = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    input  logic [XLEN-1:0]            enq_pc_0,
    input  logic [XLEN-1:0]            enq_instr_a,
    input  logic [XLEN-1:0]            enq_pc_1,
    input  logic [XLEN-1:0]            enq_instr_b,
    output logic                       enq_ready,
    input  logic                       flush,
    input  logic [1:0]                 deq_take,
    output logic                       out_valid_a,
    output logic [XLEN-1:0]            out_pc_a,
    output logic [XLEN-1:0]            out_instr_a,
    output logic                       out_valid_b,
    output logic [XLEN-1:0]            out_pc_b,
    output logic [XLEN-1:0]            out_instr_b,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_keep_a;
    logic            w_keep_b;
    logic            w_fire;
    logic [1:0]      w_n_enq;
    logic [1:0]      w_take;
    logic [CW-1:0]   w_n_deq;
    logic [PW-1:0]   w_tail_b;
    logic [PW-1:0]   w_head_b;

    // Zero instructions are end-of-image fill from fetch and are squeezed out.
    always_comb begin
        w_keep_a = !(DROP_ZERO && (enq_instr_a == '0));
        w_keep_b = !(DROP_ZERO && (enq_instr_b == '0));
        w_fire   = enq_valid && enq_ready && !flush;
        w_n_enq  = 2'd0;
        if (w_fire) begin
            w_n_enq = 2'(w_keep_a) + 2'(w_keep_b);
        end
        w_tail_b = w_keep_a ? (r_tail + PW'(1)) : r_tail;
        w_take   = (deq_take == 2'd3) ? 2'd2 : deq_take;
        w_n_deq  = (CW'(w_take) > r_count) ? r_count : CW'(w_take);
        w_head_b = r_head + PW'(1);
    end

    assign enq_ready = (r_count <= CW'(DEPTH - 2));
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_n_deq);
            r_tail  <= r_tail + PW'(w_n_enq);
            r_count <= r_count + CW'(w_n_enq) - w_n_deq;
        end
    end

    // Entry storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (!rst && w_fire) begin
            if (w_keep_a) begin
                r_mem[r_tail] <= '{pc: enq_pc_0, instr: enq_instr_a};
            end
            if (w_keep_b) begin
                r_mem[w_tail_b] <= '{pc: enq_pc_1, instr: enq_instr_b};
            end
        end
    end

    always_comb begin
        out_valid_a = (r_count >= CW'(1));
        out_valid_b = (r_count >= CW'(2));
        out_pc_a    = out_valid_a ? r_mem[r_head].pc      : '0;
        out_instr_a = out_valid_a ? r_mem[r_head].instr   : '0;
        out_pc_b    = out_valid_b ? r_mem[w_head_b].pc    : '0;
        out_instr_b = out_valid_b ? r_mem[w_head_b].instr : '0;
    end

endmodule
